// File: rtl/ex_alu_unit.sv
`timescale 1ns/1ps
// ex_alu_unit -- execute-stage ALU for the pipelined RV32 core.
//
// Takes a 4-bit ALU op from the arithmetic op decoder, two operands and a
// destination tag. Non-shift ops complete in one cycle. By default, shifts
// run on an iterative 1-bit-per-cycle shifter (latency shamt+1), so the unit
// stalls upstream through in_ready. The result is registered and held until
// the MEM stage accepts it through out_valid/out_ready.
//
// Build option: define ALU_BARREL_SHIFT_EN to compute shifts with a
// combinational barrel shifter instead. Shifts then have latency 1, the SHIFT
// state is never entered and busy stays 0. Results are identical in both
// builds.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   flush            kills in-flight and held ops on the next edge
//   in_valid/ready   upstream handshake; in_op, in_a, in_b, in_rd operands
//   out_valid/ready  downstream handshake; out_result, out_rd results
//   out_zero         out_result == 0 (registered with the result)
//   out_illegal      op code was not a supported ALU op
//   busy             iterative shift in progress
module ex_alu_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_zero,
  output logic            out_illegal,
  output logic            busy
);

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_result_r;
  logic [RD_W-1:0] out_rd_r;
  logic            out_zero_r;
  logic            out_illegal_r;
  logic            busy_r;
  logic [XLEN-1:0] shift_r;
  logic [SHW-1:0]  cnt_r;
  logic [3:0]      sop_r;
  logic [RD_W-1:0] srd_r;

  logic [SHW-1:0]  shamt_s;
  logic            accept_s;
  logic            is_shift_s;
  logic            is_legal_s;
  logic            start_iter_s;
  logic [XLEN-1:0] comb_result_s;
  logic [XLEN-1:0] shift_step_s;
  logic            shift_fin_s;
  logic [XLEN-1:0] shift_fin_result_s;

  assign shamt_s  = in_b[SHW-1:0];
  assign in_ready = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush;
  assign accept_s = in_valid && in_ready;

  // Single-cycle result of the offered op (shifts only when barrel-built or shamt is 0)
  always_comb begin
    comb_result_s = {XLEN{1'b0}};
    is_shift_s    = 1'b0;
    is_legal_s    = 1'b1;
    case (in_op)
      OP_SLL: begin
        is_shift_s = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        comb_result_s = in_a << shamt_s;
`else
        comb_result_s = in_a;
`endif
      end
      OP_SRA: begin
        is_shift_s = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        comb_result_s = $signed(in_a) >>> shamt_s;
`else
        comb_result_s = in_a;
`endif
      end
      OP_SRL: begin
        is_shift_s = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        comb_result_s = in_a >> shamt_s;
`else
        comb_result_s = in_a;
`endif
      end
      OP_ADD:  comb_result_s = in_a + in_b;
      OP_SUB:  comb_result_s = in_a - in_b;
      OP_AND:  comb_result_s = in_a & in_b;
      OP_OR:   comb_result_s = in_a | in_b;
      OP_XOR:  comb_result_s = in_a ^ in_b;
      OP_SLT:  comb_result_s = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: comb_result_s = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: begin
        is_legal_s    = 1'b0;
        comb_result_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Shifts with a zero amount finish immediately; only nonzero ones iterate
  always_comb begin
`ifdef ALU_BARREL_SHIFT_EN
    start_iter_s = 1'b0;
`else
    start_iter_s = is_shift_s && (shamt_s != CNT_ZERO);
`endif
  end

  // One-bit step of the iterative shifter for the latched op
  always_comb begin
    shift_step_s = shift_r;
    case (sop_r)
      OP_SLL:  shift_step_s = {shift_r[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, shift_r[XLEN-1:1]};
      OP_SRA:  shift_step_s = {shift_r[XLEN-1], shift_r[XLEN-1:1]};
      default: shift_step_s = shift_r;
    endcase
  end

  // The last step is taken on the completing edge so latency is exactly shamt+1
  always_comb begin
    shift_fin_s = 1'b0;
    shift_fin_result_s = shift_r;
    if (cnt_r == CNT_ZERO) begin
      shift_fin_s = 1'b1;
      shift_fin_result_s = shift_r;
    end else if (cnt_r == CNT_ONE) begin
      shift_fin_s = 1'b1;
      shift_fin_result_s = shift_step_s;
    end else begin
      shift_fin_s = 1'b0;
      shift_fin_result_s = shift_step_s;
    end
  end

  // Control FSM, iterative shifter and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      out_valid_r   <= 1'b0;
      out_result_r  <= {XLEN{1'b0}};
      out_rd_r      <= {RD_W{1'b0}};
      out_zero_r    <= 1'b0;
      out_illegal_r <= 1'b0;
      busy_r        <= 1'b0;
      shift_r       <= {XLEN{1'b0}};
      cnt_r         <= CNT_ZERO;
      sop_r         <= 4'd0;
      srd_r         <= {RD_W{1'b0}};
    end else if (flush) begin
      // flush wins over completion and over out_ready
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && start_iter_s) begin
            shift_r     <= in_a;
            cnt_r       <= shamt_s;
            sop_r       <= in_op;
            srd_r       <= in_rd;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
            state_r     <= ST_SHIFT;
          end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= comb_result_s;
            out_rd_r      <= in_rd;
            out_zero_r    <= (comb_result_s == {XLEN{1'b0}});
            out_illegal_r <= !is_legal_s;
            state_r       <= out_ready ? ST_IDLE : ST_HOLD;
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (shift_fin_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= shift_fin_result_s;
            out_rd_r      <= srd_r;
            out_zero_r    <= (shift_fin_result_s == {XLEN{1'b0}});
            out_illegal_r <= 1'b0;
            busy_r        <= 1'b0;
            cnt_r         <= CNT_ZERO;
            shift_r       <= shift_fin_result_s;
            state_r       <= out_ready ? ST_IDLE : ST_HOLD;
          end else begin
            shift_r <= shift_step_s;
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= CNT_ZERO;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_rd      = out_rd_r;
  assign out_zero    = out_zero_r;
  assign out_illegal = out_illegal_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ex_alu_unit.sv
`timescale 1ns/1ps
// Self-checking bench for ex_alu_unit: directed scenarios plus randomized
// ops compared against a behavioural model of the ALU semantics.
module tb_ex_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_zero;
  logic        out_illegal;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_alu_unit #(.XLEN(32), .SHW(5), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_zero(out_zero), .out_illegal(out_illegal), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit is_shift(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2);
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint sa, sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a << sh;
      4'd1:  return 32'($signed(a) >>> sh);
      4'd2:  return a >> sh;
      4'd5:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd6:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd7:  return a & b;
      4'd8:  return a | b;
      4'd9:  return a ^ b;
      4'd11: return (sa < sb) ? 32'd1 : 32'd0;
      4'd12: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return is_shift(op) ? int'(b % 32) + 1 : 1;
`endif
  endfunction

  function automatic int exp_busy(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 0;
`else
    return is_shift(op) ? int'(b % 32) : 0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op (waiting for in_ready), then wait for its result; returns observations
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] ord, output logic oz, output logic oill,
                        output int bcnt, output int rdy_hi);
    int guard;
    lat = -1; res = 32'd0; ord = 5'd0; oz = 1'b0; oill = 1'b0; bcnt = 0; rdy_hi = 0;
    out_ready = 1'b1;
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step(); #1; guard++;
    end
    if (guard >= 100) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      if (in_ready) rdy_hi++;
      step();
      lat++;
    end
    res = out_result; ord = out_rd; oz = out_zero; oill = out_illegal;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_rd = 5'd0;
    step(); step();
    total++;
    if ({out_valid, out_zero, out_illegal, busy, out_result, out_rd} !== 41'd0) begin
      bad++; $display("FAIL reset_por: outputs=%h want 0", {out_valid, out_zero, out_illegal, busy, out_result, out_rd});
    end
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    // start a long sra and reset it mid-flight
    in_op = 4'd1; in_a = $urandom; in_b = 32'd10; in_rd = 5'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total++;
    if (busy !== (exp_busy(4'd1, 32'd10) > 2)) begin
      bad++; $display("FAIL reset_midshift_busy: busy=%b want %b", busy, exp_busy(4'd1, 32'd10) > 2);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_zero, out_illegal, busy, out_result, out_rd} !== 41'd0) begin
      bad++; $display("FAIL reset_async: outputs=%h want 0", {out_valid, out_zero, out_illegal, busy, out_result, out_rd});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_midshift_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      step();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL reset_stale: out_valid cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_add_sub();
    int lat, bc, rh; logic [31:0] res; logic [4:0] ord; logic oz, oill;
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd3, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'd0 || oz !== 1'b1 || lat != 1 || ord !== 5'd3) begin
      bad++; $display("FAIL add_wrap: res=%h zero=%b lat=%0d rd=%0d want 00000000/1/1/3", res, oz, lat, ord);
    end
    run_op(4'd6, 32'd0, 32'd1, 5'd4, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'hFFFF_FFFF || oz !== 1'b0 || lat != 1) begin
      bad++; $display("FAIL sub_wrap: res=%h zero=%b lat=%0d want ffffffff/0/1", res, oz, lat);
    end
  endtask

  task automatic test_compare();
    int lat, bc, rh; logic [31:0] res; logic [4:0] ord; logic oz, oill;
    run_op(4'd11, 32'h8000_0000, 32'd1, 5'd5, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'd1 || lat != 1) begin
      bad++; $display("FAIL slt: res=%h lat=%0d want 00000001/1", res, lat);
    end
    run_op(4'd12, 32'h8000_0000, 32'd1, 5'd6, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'd0 || oz !== 1'b1) begin
      bad++; $display("FAIL sltu: res=%h zero=%b want 00000000/1", res, oz);
    end
  endtask

  task automatic test_sra();
    int lat, bc, rh; logic [31:0] res; logic [4:0] ord; logic oz, oill;
    run_op(4'd1, 32'h8000_0000, 32'd31, 5'd8, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'hFFFF_FFFF || ord !== 5'd8) begin
      bad++; $display("FAIL sra31_result: res=%h rd=%0d want ffffffff/8", res, ord);
    end
    total++;
    if (lat != exp_lat(4'd1, 32'd31) || bc != exp_busy(4'd1, 32'd31) || rh != 0) begin
      bad++; $display("FAIL sra31_timing: lat=%0d busy=%0d ready_hi=%0d want %0d/%0d/0",
                      lat, bc, rh, exp_lat(4'd1, 32'd31), exp_busy(4'd1, 32'd31));
    end
    run_op(4'd2, 32'h1234_5678, 32'hFFFF_FFE0, 5'd9, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'h1234_5678 || lat != 1) begin
      bad++; $display("FAIL shamt0: res=%h lat=%0d want 12345678/1", res, lat);
    end
  endtask

  task automatic test_illegal();
    int lat, bc, rh; logic [31:0] res; logic [4:0] ord; logic oz, oill;
    run_op(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 5'd10, lat, res, ord, oz, oill, bc, rh);
    total++;
    if (res !== 32'd0 || oill !== 1'b1 || lat != 1) begin
      bad++; $display("FAIL illegal13: res=%h illegal=%b lat=%0d want 00000000/1/1", res, oill, lat);
    end
  endtask

  task automatic test_random();
    int lat, bc, rh; logic [31:0] res, a, b, want; logic [4:0] ord, rd; logic oz, oill;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; rd = 5'($urandom);
      if (i % 5 == 0) b = 32'd0;
      want = ref_alu(op, a, b);
      run_op(op, a, b, rd, lat, res, ord, oz, oill, bc, rh);
      total++;
      if (res !== want || ord !== rd || oz !== (want == 32'd0) || oill !== !is_legal(op)) begin
        bad++; $display("FAIL rand_result op=%0d a=%h b=%h: res=%h rd=%0d z=%b ill=%b want %h/%0d/%b/%b",
                        op, a, b, res, ord, oz, oill, want, rd, want == 32'd0, !is_legal(op));
      end
      total++;
      if (lat != exp_lat(op, b) || bc != exp_busy(op, b)) begin
        bad++; $display("FAIL rand_timing op=%0d b=%h: lat=%0d busy=%0d want %0d/%0d",
                        op, b, lat, bc, exp_lat(op, b), exp_busy(op, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] aa [3];
    logic [31:0] bb [3];
    logic [31:0] res_q [$];
    int cyc_q [$];
    int sent;
    bit acc;
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    in_op = 4'd9; in_a = 32'hF0F0_F0F0; in_b = 32'hFF00_FF00; in_rd = 5'd12; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0FF0_0FF0 || out_rd !== 5'd12 || out_zero !== 1'b0) begin
        bad++; $display("FAIL hold_stable cyc%0d: v=%b res=%h rd=%0d z=%b want 1/0ff00ff0/12/0",
                        i, out_valid, out_result, out_rd, out_zero);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_ready cyc%0d: in_ready=%b want 0", i, in_ready);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      aa[i] = $urandom; bb[i] = $urandom;
    end
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        res_q.push_back(out_result);
        cyc_q.push_back(c);
      end
      if (sent < 3) begin
        in_valid = 1'b1; in_op = 4'd7; in_a = aa[sent]; in_b = bb[sent]; in_rd = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    total++;
    if (res_q.size() != 4) begin
      bad++; $display("FAIL b2b_count: results=%0d want 4", res_q.size());
    end else begin
      total++;
      if (res_q[0] !== 32'h0FF0_0FF0) begin
        bad++; $display("FAIL b2b_first: res=%h want 0ff00ff0", res_q[0]);
      end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (res_q[i] !== ref_alu(4'd7, aa[i-1], bb[i-1]) || cyc_q[i] != cyc_q[1] + i - 1) begin
          bad++; $display("FAIL b2b_and%0d: res=%h cyc=%0d want %h cyc=%0d",
                          i, res_q[i], cyc_q[i], ref_alu(4'd7, aa[i-1], bb[i-1]), cyc_q[1] + i - 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    in_op = 4'd0; in_a = $urandom; in_b = 32'd20; in_rd = 5'd9; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_pre_ready: in_ready=%b want 1", in_ready);
    end
    step();                      // cycle 1: accepted
    in_valid = 1'b0;
    step(); step(); step();      // cycle 4
    flush = 1'b1;
    in_op = 4'd5; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_same_cycle_ready: in_ready=%b want 0", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_after: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL flush_no_result: out_valid cycles=%0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_compare();
    test_sra();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
